// File: rtl/load_store_unit.sv
// load_store_unit: memory-side executor for loads and stores.
// Aligns store data/strobes to the address, runs a req/gnt/rvalid handshake
// with the data bus, extends load data and stalls the core until done.
// Misaligned or malformed accesses are rejected with a one-cycle access_err.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   MemRead, MemWrite       load/store request from the decoder
//   byte_enable, funct3     access size (0001/0011/1111), funct3[2]=unsigned load
//   addr, wdata             effective address, right-justified store data
//   stall                   holds the core while an access is in progress
//   load_data, load_valid   extended load result, valid in the DONE cycle
//   access_err              one-cycle pulse after a rejected access
//   mem_req/we/addr/be/wdata  bus request fields (zero when mem_req=0)
//   mem_gnt, mem_rvalid, mem_rdata  bus grant and read response
module load_store_unit #(
    parameter int unsigned bitwidth = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [3:0]          byte_enable,
    input  logic [2:0]          funct3,
    input  logic [bitwidth-1:0] addr,
    input  logic [bitwidth-1:0] wdata,
    output logic                stall,
    output logic [bitwidth-1:0] load_data,
    output logic                load_valid,
    output logic                access_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [bitwidth-1:0] mem_addr,
    output logic [3:0]          mem_be,
    output logic [bitwidth-1:0] mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [bitwidth-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitR, StDone} state_e;

    state_e              state_q, state_d;
    logic                we_q;
    logic [bitwidth-1:0] addr_q;
    logic [3:0]          be_q;
    logic [bitwidth-1:0] wdata_q;
    logic [1:0]          off_q;
    logic [3:0]          size_q;
    logic                uns_q;
    logic [bitwidth-1:0] load_data_q;
    logic                err_q;

    logic                access;
    logic                size_ok;
    logic                legal;
    logic                reject;
    logic [1:0]          off;
    logic [bitwidth-1:0] sh;
    logic [bitwidth-1:0] ext_data;
    logic                in_req;

    // Only funct3[2] matters here.
    logic unused_funct3;
    assign unused_funct3 = ^funct3[1:0];

    assign off = addr[1:0];

    always_comb begin
        access  = MemRead | MemWrite;
        size_ok = 1'b0;
        unique case (byte_enable)
            4'b0001: size_ok = 1'b1;
            4'b0011: size_ok = ~off[0];
            4'b1111: size_ok = (off == 2'b00);
            default: size_ok = 1'b0;
        endcase
        legal  = access && !(MemRead && MemWrite) && size_ok;
        reject = access && !legal;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (legal) state_d = StReq;
            StReq:   if (mem_gnt) state_d = we_q ? StDone : StWaitR;
            StWaitR: if (mem_rvalid) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Load extraction from the captured lane offset and size.
    always_comb begin
        sh       = mem_rdata >> {off_q, 3'b000};
        ext_data = sh;
        unique case (size_q)
            4'b0001: ext_data = uns_q ? {{(bitwidth-8){1'b0}}, sh[7:0]}
                                      : {{(bitwidth-8){sh[7]}}, sh[7:0]};
            4'b0011: ext_data = uns_q ? {{(bitwidth-16){1'b0}}, sh[15:0]}
                                      : {{(bitwidth-16){sh[15]}}, sh[15:0]};
            default: ext_data = sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= 4'b0000;
            wdata_q     <= '0;
            off_q       <= 2'b00;
            size_q      <= 4'b0000;
            uns_q       <= 1'b0;
            load_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == StIdle) && reject;
            if (state_q == StIdle && legal) begin
                we_q    <= MemWrite;
                addr_q  <= {addr[bitwidth-1:2], 2'b00};
                be_q    <= byte_enable << off;
                wdata_q <= wdata << {off, 3'b000};
                off_q   <= off;
                size_q  <= byte_enable;
                uns_q   <= funct3[2];
            end
            if (state_q == StWaitR && mem_rvalid) begin
                load_data_q <= ext_data;
            end
        end
    end

    assign in_req     = (state_q == StReq);
    assign mem_req    = in_req;
    assign mem_we     = in_req & we_q;
    assign mem_addr   = in_req ? addr_q : '0;
    assign mem_be     = in_req ? be_q : 4'b0000;
    assign mem_wdata  = in_req ? wdata_q : '0;

    // Combinational stall in IDLE so the core holds from the request cycle on.
    assign stall = reset_n && (((state_q == StIdle) && legal) ||
                               (state_q == StReq) || (state_q == StWaitR));

    assign load_valid = (state_q == StDone) && !we_q;
    assign load_data  = load_data_q;
    assign access_err = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        reset_n;
    logic        MemRead;
    logic        MemWrite;
    logic [3:0]  byte_enable;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        access_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.bitwidth(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .byte_enable (byte_enable),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .access_err  (access_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

    typedef struct {
        logic        re;
        logic        we;
        logic [3:0]  be;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        byte_enable = 4'b0000;
        funct3      = 3'b000;
        addr        = 32'h0;
        wdata       = 32'h0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        MemRead     = v.re;
        MemWrite    = v.we;
        byte_enable = v.be;
        funct3      = v.f3;
        addr        = v.a;
        wdata       = v.wd;
        mem_gnt     = 1'b1;
        @(negedge clk);
        chk({tag, " idle stall"}, {31'b0, stall}, {31'b0, !v.err});
        chk({tag, " idle req"}, {31'b0, mem_req}, 32'h0);
        if (v.err) begin
            step();
            clear_inputs();
            @(negedge clk);
            chk({tag, " err pulse"}, {31'b0, access_err}, 32'h1);
            chk({tag, " err no req"}, {31'b0, mem_req}, 32'h0);
            chk({tag, " err stall"}, {31'b0, stall}, 32'h0);
            step();
            @(negedge clk);
            chk({tag, " err drop"}, {31'b0, access_err}, 32'h0);
            chk({tag, " err still no req"}, {31'b0, mem_req}, 32'h0);
        end else begin
            step();
            @(negedge clk);
            chk({tag, " req"}, {31'b0, mem_req}, 32'h1);
            chk({tag, " we"}, {31'b0, mem_we}, {31'b0, v.we});
            chk({tag, " addr"}, mem_addr, v.exp_maddr);
            chk({tag, " be"}, {28'b0, mem_be}, {28'b0, v.exp_be});
            if (v.we) chk({tag, " wdata"}, mem_wdata, v.exp_wdata);
            chk({tag, " req stall"}, {31'b0, stall}, 32'h1);
            step();
            mem_gnt = 1'b0;
            if (v.we) begin
                clear_inputs();
                @(negedge clk);
                chk({tag, " done stall"}, {31'b0, stall}, 32'h0);
                chk({tag, " st no lv"}, {31'b0, load_valid}, 32'h0);
                chk({tag, " done req"}, {31'b0, mem_req}, 32'h0);
                chk({tag, " done be"}, {28'b0, mem_be}, 32'h0);
            end else begin
                mem_rvalid = 1'b1;
                mem_rdata  = v.rd;
                @(negedge clk);
                chk({tag, " waitr stall"}, {31'b0, stall}, 32'h1);
                chk({tag, " waitr req"}, {31'b0, mem_req}, 32'h0);
                step();
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
                clear_inputs();
                @(negedge clk);
                chk({tag, " lv"}, {31'b0, load_valid}, 32'h1);
                chk({tag, " load"}, load_data, v.exp_load);
                chk({tag, " done stall"}, {31'b0, stall}, 32'h0);
            end
            step();
            @(negedge clk);
            chk({tag, " lv after"}, {31'b0, load_valid}, 32'h0);
        end
        step();
    endtask

    initial begin
        logic [31:0] held;
        int          lv_cnt;
        //          re    we    be       f3      addr          wdata         rdata         err   maddr         be       wdata         load
        vecs[0]  = '{1'b0, 1'b1, 4'b1111, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 4'b0001, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        1'b0, 32'h0000_0100, 4'b1000, 32'hA500_0000, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 4'b0001, 3'b000, 32'h0000_0102, 32'h0,         32'h1280_3456, 1'b0, 32'h0000_0100, 4'b0100, 32'h0,         32'hFFFF_FF80};
        vecs[3]  = '{1'b1, 1'b0, 4'b0001, 3'b100, 32'h0000_0102, 32'h0,         32'h1280_3456, 1'b0, 32'h0000_0100, 4'b0100, 32'h0,         32'h0000_0080};
        vecs[4]  = '{1'b1, 1'b0, 4'b0011, 3'b001, 32'h0000_0102, 32'h0,         32'h1280_3456, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,         32'h0000_1280};
        vecs[5]  = '{1'b1, 1'b0, 4'b0011, 3'b001, 32'h0000_0101, 32'h0,         32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 1'b1, 4'b1111, 3'b010, 32'h0000_0100, 32'h0,         32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
        vecs[7]  = '{1'b1, 1'b0, 4'b0111, 3'b010, 32'h0000_0100, 32'h0,         32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};
        vecs[8]  = '{1'b1, 1'b0, 4'b1111, 3'b010, 32'h0000_0200, 32'h0,         32'h89AB_CDEF, 1'b0, 32'h0000_0200, 4'b1111, 32'h0,         32'h89AB_CDEF};
        vecs[9]  = '{1'b1, 1'b0, 4'b0011, 3'b001, 32'h0000_0200, 32'h0,         32'h1234_ABCD, 1'b0, 32'h0000_0200, 4'b0011, 32'h0,         32'hFFFF_ABCD};
        vecs[10] = '{1'b1, 1'b0, 4'b0011, 3'b101, 32'h0000_0202, 32'h0,         32'hBEEF_1234, 1'b0, 32'h0000_0200, 4'b1100, 32'h0,         32'h0000_BEEF};
        vecs[11] = '{1'b0, 1'b1, 4'b0011, 3'b001, 32'h0000_0106, 32'h0000_CAFE, 32'h0,        1'b0, 32'h0000_0104, 4'b1100, 32'hCAFE_0000, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 4'b0001, 3'b000, 32'h0000_0101, 32'h0,         32'h0000_FF00, 1'b0, 32'h0000_0100, 4'b0010, 32'h0,         32'hFFFF_FFFF};
        vecs[13] = '{1'b0, 1'b1, 4'b1111, 3'b010, 32'h0000_0102, 32'h1111_2222, 32'h0,        1'b1, 32'h0,         4'b0000, 32'h0,         32'h0};

        reset_n    = 1'b0;
        clear_inputs();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        step();
        step();
        @(negedge clk);
        chk("rst req", {31'b0, mem_req}, 32'h0);
        chk("rst stall", {31'b0, stall}, 32'h0);
        chk("rst load_data", load_data, 32'h0);
        chk("rst lv", {31'b0, load_valid}, 32'h0);
        chk("rst err", {31'b0, access_err}, 32'h0);
        step();
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vecs[i]);
        end

        // Store must leave the last load result untouched.
        held = load_data;
        chk("held after load", held, 32'hFFFF_FFFF);
        run_vec(100, vecs[0]);
        chk("load_data held over store", load_data, 32'hFFFF_FFFF);

        // LW with 3 gnt wait states and 2 rvalid wait states.
        MemRead     = 1'b1;
        byte_enable = 4'b1111;
        funct3      = 3'b010;
        addr        = 32'h0000_0300;
        mem_gnt     = 1'b0;
        @(negedge clk);
        chk("slow idle stall", {31'b0, stall}, 32'h1);
        step();
        // rvalid outside WAIT_R must be ignored.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) mem_gnt = 1'b1;
            @(negedge clk);
            chk($sformatf("slow req%0d", k), {31'b0, mem_req}, 32'h1);
            chk($sformatf("slow addr%0d", k), mem_addr, 32'h0000_0300);
            chk($sformatf("slow be%0d", k), {28'b0, mem_be}, 32'h0000_000F);
            chk($sformatf("slow we%0d", k), {31'b0, mem_we}, 32'h0);
            chk($sformatf("slow stall%0d", k), {31'b0, stall}, 32'h1);
            chk($sformatf("slow lv%0d", k), {31'b0, load_valid}, 32'h0);
            step();
            mem_rvalid = 1'b0;
        end
        mem_gnt = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("slow wait stall%0d", k), {31'b0, stall}, 32'h1);
            chk($sformatf("slow wait req%0d", k), {31'b0, mem_req}, 32'h0);
            step();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0102_0304;
        @(negedge clk);
        chk("slow rv stall", {31'b0, stall}, 32'h1);
        step();
        mem_rvalid = 1'b0;
        clear_inputs();
        lv_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (load_valid === 1'b1) lv_cnt++;
            if (k == 0) chk("slow load", load_data, 32'h0102_0304);
            step();
        end
        chk("slow lv count", lv_cnt, 32'd1);

        // Reset in WAIT_R, then a stale response.
        MemRead     = 1'b1;
        byte_enable = 4'b1111;
        funct3      = 3'b010;
        addr        = 32'h0000_0400;
        mem_gnt     = 1'b1;
        step();
        step();
        mem_gnt = 1'b0;
        @(negedge clk);
        chk("pre-rst waitr stall", {31'b0, stall}, 32'h1);
        reset_n = 1'b0;
        clear_inputs();
        step();
        @(negedge clk);
        chk("mid rst stall", {31'b0, stall}, 32'h0);
        chk("mid rst req", {31'b0, mem_req}, 32'h0);
        chk("mid rst addr", mem_addr, 32'h0);
        chk("mid rst load_data", load_data, 32'h0);
        chk("mid rst lv", {31'b0, load_valid}, 32'h0);
        reset_n    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        step();
        mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post rst lv%0d", k), {31'b0, load_valid}, 32'h0);
            chk($sformatf("post rst data%0d", k), load_data, 32'h0);
            chk($sformatf("post rst req%0d", k), {31'b0, mem_req}, 32'h0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

- Sits between the core datapath and the data-memory bus.
- Executes the memory side of the decoder's `MemRead` / `MemWrite` / `byte_enable` controls:
  - aligns store data and byte strobes to the address;
  - runs a request/grant/response handshake with memory;
  - extracts and sign/zero-extends load data;
  - stalls the core until the access completes.
- Misaligned or malformed accesses are rejected without touching the bus.

## Interface
- `bitwidth`, default 32: data/address width. Only 32 is supported.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `MemRead` in 1: load request from the decoder.
- `MemWrite` in 1: store request from the decoder.
- `byte_enable` in 4: access size. `0001` = byte, `0011` = half, `1111` = word.
- `funct3` in 3: instruction funct3. Bit 2 = 1 selects unsigned load (LBU/LHU).
- `addr` in bitwidth: effective address from the ALU.
- `wdata` in bitwidth: store data (rs2), right-justified.
- `stall` out 1: holds the core while an access is in progress.
- `load_data` out bitwidth: extended load result.
- `load_valid` out 1: `load_data` valid this cycle.
- `access_err` out 1: one-cycle pulse for a rejected access.
- `mem_req` out 1: bus request.
- `mem_we` out 1: 1 = write.
- `mem_addr` out bitwidth: word-aligned address (`addr & ~3`).
- `mem_be` out 4: lane strobes.
- `mem_wdata` out bitwidth: lane-aligned write data.
- `mem_gnt` in 1: request accepted.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in bitwidth: read data.

## Operation
- States: IDLE, REQ, WAIT_R, DONE.
- **Access check in IDLE**, with `off = addr[1:0]`.
  - Legal: `byte_enable=0001` with any `off`; `0011` with `off[0]=0`; `1111` with `off=00`.
  - Rejected: any other `byte_enable`, or `MemRead` and `MemWrite` both high.
- **Legal access in IDLE:**
  - Capture the access.
  - Drive `mem_addr`, `mem_we=MemWrite`, `mem_be = byte_enable << off`, `mem_wdata = wdata << (8*off)`.
  - Capture the extension mode from `funct3[2]` and the size from `byte_enable`.
  - Go to REQ.
- **Rejected access in IDLE:** no bus activity; `access_err=1` next cycle; stay IDLE.
- **REQ:** `mem_req=1`. Address, strobes and data stay stable until `mem_gnt`.
  - `mem_gnt` on a store: go to DONE.
  - `mem_gnt` on a load: go to WAIT_R.
- **WAIT_R:** on `mem_rvalid`:
  - `sh = mem_rdata >> (8*off)`.
  - Byte: `load_data = ext(sh[7:0])`. Half: `load_data = ext(sh[15:0])`. Word: `load_data = sh`.
  - `ext` sign-extends when `funct3[2]=0`, zero-extends when `funct3[2]=1`.
  - Register the result and go to DONE.
- **DONE:** one cycle. `load_valid=1` for loads. Inputs are ignored because the same instruction is still presented. Return to IDLE.
- `mem_req` and bus fields drop to 0 on leaving REQ. `mem_be` and `mem_wdata` are 0 whenever `mem_req=0`.

## Timing
- **`stall`:**
  - Combinational: 1 in IDLE when a legal `MemRead` or `MemWrite` is present.
  - 1 throughout REQ and WAIT_R.
  - 0 in DONE and for rejected accesses.
- **Latency:**
  - Store with `mem_gnt` in the first REQ cycle: stall for 2 cycles (IDLE and REQ); DONE in cycle 2.
  - Load with gnt in the first REQ cycle and rvalid one cycle later: stall for 3 cycles; `load_valid` in cycle 3.
- **Handshake:**
  - `mem_rvalid` counts only in WAIT_R. It cannot complete in the gnt cycle, and is ignored in IDLE, REQ and DONE.
  - Wait states on gnt/rvalid are unbounded. There is no timeout.
- **`load_data`** holds its last value until the next load completes. `load_valid` is high only in DONE.
- **Reset** (`reset_n=0` at an edge, in any state):
  - state = IDLE.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, `load_data`, `load_valid`, `access_err` = 0.
  - `stall` = 0 while in reset.
  - A response arriving after reset mid-access is ignored.

## Test plan
- SW to `addr=0x100`, `wdata=0xDEADBEEF`, `mem_gnt` tied 1 -> one REQ cycle with `mem_addr=0x100`, `mem_be=1111`, `mem_wdata=0xDEADBEEF`, `mem_we=1`; `stall` high 2 cycles; no `load_valid`.
- SB to `addr=0x103`, `wdata=0x000000A5` -> `mem_addr=0x100`, `mem_be=1000`, `mem_wdata=0xA5000000`.
- LB at `0x102` with `mem_rdata=0x12803456` -> `load_data=0xFFFFFF80`. Repeat with `funct3=100` (LBU) -> `0x00000080`. LH at `0x102` -> `0x00001280`.
- LH at `0x101` -> no `mem_req`; `access_err` one-cycle pulse; `stall=0`. Same for `MemRead=MemWrite=1` and for `byte_enable=0111`.
- LW with `mem_gnt` delayed 3 cycles and `mem_rvalid` delayed 2 further cycles -> `mem_req`, `mem_addr`, `mem_be` stable throughout; `stall` continuous; `load_valid` exactly one cycle.
- Reset asserted in WAIT_R, then `mem_rvalid` pulsed -> all outputs 0, state IDLE, `load_valid` stays 0.
